mul_seq_xnyn: RTL
=================

// Module: mul_seq_xnyn
// PURPOSE
//  Parametrised sequential (radix-2 shift-add) multiplier; successor to the fixed 2x2 unsigned
//  and 3x3 signed combinational multipliers. Multiplies two W-bit operands, unsigned or
//  two's-complement selected per operation, with valid/ready handshakes on input and result.
//  Sits behind the 8-bit io_in/io_out tile wrapper. Result lands on p, sign on s, and
//  readiness on rdy (=in_ready).
// PARAMETERS
//  W      2   operand width, legal 2..16; product width is 2*W
//  CNTW   -   localparam, $clog2(W+1), iteration counter width
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  x          in   W    multiplicand, sampled on accept
//  y          in   W    multiplier, sampled on accept
//  sgn        in   1    1 = signed (two's complement) operands; sampled on accept
//  in_valid   in   1    operands presented
//  in_ready   out  1    block can accept (drives rdy)
//  p          out  2W   product (two's complement when sgn was 1)
//  s          out  1    result sign: 1 only if signed op and product < 0
//  out_valid  out  1    p/s valid
//  out_ready  in   1    consumer takes result
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, p=0, s=0, out_valid=0, in_ready=1,
//    counter=0. Reset mid-operation discards the op; no partial result is ever presented.
//  - FSM states: IDLE -> RUN -> FIX -> DONE -> IDLE.
//    IDLE: in_ready=1; on in_valid, at edge t0: latch |x|,|y| (magnitudes if sgn, raw if not),
//      neg = sgn & (x[W-1]^y[W-1]), acc=0, cnt=0 -> RUN.
//    RUN: one bit of multiplier per cycle: if mplr[0], acc += mcand<<cnt (or shift-right acc);
//      cnt++. After W iterations (edge t0+W) -> FIX.
//    FIX: if neg, p <= -acc (2W-bit two's complement), else p <= acc; s <= neg & (acc!=0)
//      -> DONE at edge t0+W+1.
//    DONE: out_valid=1, p/s held stable; on out_ready -> IDLE (p/s keep value, out_valid=0).
//  - Latency: out_valid first high after edge t0+W+1; throughput one op per W+3 cycles minimum.
//  - in_ready=1 only in IDLE; in_valid in RUN/FIX/DONE is ignored (not queued).
//  - Backpressure: DONE persists indefinitely while out_ready=0; p, s, out_valid stable.
//  - Width rules: magnitude of -2^(W-1) is 2^(W-1), held in W bits unsigned; accumulator is
//    2W bits, no overflow possible. (-2^(W-1))^2 = 2^(2W-2) fits as positive 2W-bit signed.
//  - Zero product with neg=1 yields p=0, s=0 (no negative zero).
//  - sgn=0: neg forced 0, operands used raw; s always 0.
//  - X/Z on inputs outside accept cycle must not affect state.
// STRUCTURE
//  - Package mul_seq_pkg: state enum {IDLE,RUN,FIX,DONE}, 2-bit encoding; function
//    abs_w(value, sgn) and neg_2w; mode constant MODE_UNSIGNED=0/MODE_SIGNED=1.
//  - One sub-module natural: mul_seq_dp (operand/acc registers, adder, shift, final negate);
//    FSM and counter stay in mul_seq_xnyn. Tile wrapper top_mulu_xnyn maps io pins, W=2.
// TESTING
//  1. W=2, sgn=0, x=3, y=3 -> p=4'b1001, s=0; out_valid high after edge t0+3, exactly W+1.
//  2. W=2, sgn=1, x=2'b10(-2), y=2'b11(-1) -> p=4'b0010, s=0; x=2'b10, y=2'b01 -> p=4'b1110, s=1.
//  3. W=4, sgn=1: -8*-8 -> p=8'h40, s=0; -8*7 -> p=8'hC8, s=1; sgn=0 15*15 -> p=8'hE1, s=0.
//  4. W=4, sgn=1, x=4'hF(-1), y=0 -> p=0, s=0 (no negative zero).
//  5. Backpressure: hold out_ready=0 5 cycles in DONE while toggling in_valid/x/y -> p,s stable,
//     in_ready=0, no new op accepted; release -> IDLE next edge, in_ready=1.
//  6. Assert rst during RUN (cycle t0+1) -> immediately out_valid=0, p=0, in_ready=1; after
//     release, new op 2*3 (W=2, unsigned) -> p=6 with normal latency.
//  Plus: random W in {2,3,4,8}, both modes, vs. reference model x*y, back-to-back ops.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and constants for the sequential shift-add multiplier
package mul_seq_pkg;

  // Control states: operand capture, shift-add iterations, sign fix-up, result hold
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Product is negative only for signed ops whose operand signs differ
  function automatic logic op_is_neg(input logic sgn, input logic x_msb, input logic y_msb);
    return sgn & (x_msb ^ y_msb);
  endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// rtl/mul_seq_dp.sv - operand/accumulator datapath with magnitude capture and final negate
module mul_seq_dp
  import mul_seq_pkg::*;
#(
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           sgn,
  output logic [2*W-1:0] o_p_fix,
  output logic           o_s_fix
);

  // Magnitude of a W-bit operand; -2^(W-1) maps to 2^(W-1), which still fits unsigned in W bits
  function automatic logic [W-1:0] abs_w(input logic [W-1:0] v, input logic sg);
    return (sg && v[W-1]) ? -v : v;
  endfunction

  // 2W-bit two's complement negate of the accumulated magnitude
  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    return -v;
  endfunction

  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplr;
  logic [2*W-1:0] r_acc;
  logic           r_neg;

  // Capture magnitudes on accept, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
    end else if (i_load) begin
      r_mcand <= {{W{1'b0}}, abs_w(x, sgn)};
      r_mplr  <= abs_w(y, sgn);
      r_acc   <= '0;
      r_neg   <= op_is_neg(sgn, x[W-1], y[W-1]);
    end else if (i_step) begin
      if (r_mplr[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
    end
  end

  // Sign fix-up; a zero magnitude never produces a negative result
  always_comb begin
    o_p_fix = r_neg ? neg_2w(r_acc) : r_acc;
    o_s_fix = r_neg & (|r_acc);
  end

endmodule

// File: rtl/mul_seq_xnyn.sv
// rtl/mul_seq_xnyn.sv - W x W radix-2 sequential multiplier with valid/ready handshakes
module mul_seq_xnyn
  import mul_seq_pkg::*;
#(
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           sgn,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*W-1:0] p,
  output logic           s,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int CNTW = $clog2(W + 1);

  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [2*W-1:0]  r_p;
  logic            r_s;
  logic            r_out_valid;
  logic            r_in_ready;

  logic            w_load;
  logic            w_step;
  logic [2*W-1:0]  w_p_fix;
  logic            w_s_fix;

  // Datapath strobes: inputs are only sampled on the accept cycle
  always_comb begin
    w_load = (r_state == IDLE) && in_valid;
    w_step = (r_state == RUN);
  end

  mul_seq_dp #(.W(W)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .x       (x),
    .y       (y),
    .sgn     (sgn),
    .o_p_fix (w_p_fix),
    .o_s_fix (w_s_fix)
  );

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_p         <= '0;
      r_s         <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNTW'(1);
          if (r_cnt == CNTW'(W - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_p         <= w_p_fix;
          r_s         <= w_s_fix;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign p         = r_p;
  assign s         = r_s;
  assign out_valid = r_out_valid;

endmodule
